frame_uart_sender: RTL and testbench
====================================

Name: frame_uart_sender

Overview:
- Reader side of the ping-pong SPRAM frame buffers. The writer side (UART receive into a bank) commits a frame. This block then reads that frame byte-by-byte from the idle bank and feeds a uart_tx byte interface (tx_start / tx_data / tx_busy).
- Gated by a host enable, derived from the PC command bytes 0xAB (start) and 0xCD (stop).
- Sits between the SPRAM read port mux and the PC- or vector-side uart_tx.

Parameters:
- ADDR_W, 14, SPRAM word address width.
- LEN_W, 14, frame length width in bytes.
- BUSY_TIMEOUT, 1023, max cycles to wait for tx_busy to rise after tx_start; must be ≥ 1.

Ports:
- clk  in  1  system clock (clk_15m36 domain).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  host gate; 1 = sending permitted.
- frame_valid  in  1  pulse: a committed frame is available.
- frame_base  in  ADDR_W  first word address of the frame; sampled on accept.
- frame_len  in  LEN_W  byte count; sampled on accept.
- frame_ready  out  1  block can accept a frame this cycle.
- mem_rd_en  out  1  read strobe to SPRAM.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  16  SPRAM DATAOUT; valid 1 cycle after mem_rd_en; only [7:0] used.
- tx_start  out  1  uart_tx start request.
- tx_data  out  8  uart_tx byte.
- tx_busy  in  1  uart_tx busy.
- busy  out  1  frame in progress.
- done  out  1  1-cycle pulse: frame fully sent.
- aborted  out  1  1-cycle pulse: frame ended early (enable dropped or timeout).
- overrun  out  1  sticky: frame_valid arrived while frame_ready = 0.
- tx_timeout  out  1  sticky: tx_busy failed to rise within BUSY_TIMEOUT.
- frames_sent  out  16  count of completed frames; wraps at 0xFFFF→0.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Reset mid-frame abandons the frame immediately and tx_start drops asynchronously. No done or aborted pulse is produced.
- frame_ready = (state == IDLE) & enable.
- A frame is accepted when frame_valid & frame_ready. frame_base and frame_len are registered, and the byte index is set to 0.
- FSM states:
  - IDLE: if accepted and frame_len == 0, pulse done, increment frames_sent, stay IDLE. If accepted and frame_len > 0, go to READ.
  - READ: mem_rd_en = 1 for exactly 1 cycle; mem_addr = frame_base + index, modulo 2^ADDR_W (wraps, no error). Go to WAIT_RD.
  - WAIT_RD: register mem_rdata[7:0] into tx_data at the end of this cycle. Go to LAUNCH.
  - LAUNCH: tx_start = 1 and tx_data held stable.
    - tx_busy sampled high → tx_start = 0 next cycle; go to DRAIN.
    - Timeout counter reaches BUSY_TIMEOUT with tx_busy low → set tx_timeout, pulse aborted, go to IDLE.
  - DRAIN: wait while tx_busy = 1. When tx_busy = 0, increment index.
    - index + 1 == frame_len → pulse done, increment frames_sent, go to IDLE.
    - else if enable = 0 → pulse aborted, go to IDLE.
    - else go to READ.
- Latency from accept at cycle 0: mem_rd_en at cycle 1, tx_data valid at cycle 3, tx_start asserted from cycle 3. Between bytes, the gap is 3 cycles from tx_busy falling to the next tx_start.
- A byte is never truncated. Enable dropping in READ, WAIT_RD or LAUNCH still completes the current byte; the abort is taken in DRAIN.
- If tx_busy is already high when entering LAUNCH, tx_start still asserts and the byte counts as launched at the first busy-high sample.
- frame_valid while not ready sets overrun; the frame is dropped; the FSM is unaffected.
- frame_valid on the same cycle as a done pulse is not accepted, because ready is low in the done cycle for a frame_len > 0 completion.
- busy = (state != IDLE).
- mem_rd_en and mem_addr are registered outputs. mem_addr holds its last value when idle.

Test Plan:
1. enable = 1; frame_base = 0x0010, frame_len = 3; memory bytes 0xA1, 0xB2, 0xC3; uart model raises busy 2 cycles after start and holds it 20 cycles.
   -> tx_data sequence A1, B2, C3; mem_rd_en at cycle 1; first tx_start at cycle 3; one done pulse; frames_sent = 1.
2. frame_len = 0 with enable = 1.
   -> done pulse in the accept cycle; no mem_rd_en; no tx_start; frames_sent increments.
3. frame_base = 0x3FFE, frame_len = 4.
   -> mem_addr sequence 3FFE, 3FFF, 0000, 0001; 4 bytes sent.
4. frame_len = 5; enable dropped during byte 2's LAUNCH.
   -> byte 2 completes; aborted pulses in DRAIN; no done; frames_sent unchanged; frame_ready = 0 until enable = 1.
5. Second frame_valid while busy; then tx_busy held low forever on the next frame with BUSY_TIMEOUT = 8.
   -> overrun = 1 and stays 1; tx_timeout = 1 after 8 LAUNCH cycles; aborted pulse; back to IDLE.
6. rst asserted mid-DRAIN.
   -> all outputs 0 immediately (asynchronous); after release, a new frame is accepted normally.

Source files
------------

// File: rtl/frame_uart_sender.sv
// frame_uart_sender: reader side of the ping-pong SPRAM frame buffers.
// Takes a committed frame (base word address + byte count), reads it one
// byte per SPRAM word from the idle bank and hands each byte to a uart_tx
// byte interface, one byte at a time, gated by the host enable.
//
// Handshakes:
//   frame_valid/frame_ready : a frame is accepted in any cycle where both
//     are high; frame_valid without frame_ready drops the frame and sets the
//     sticky overrun flag.
//   tx_start/tx_busy : tx_start is raised with tx_data stable and held until
//     tx_busy is sampled high (the byte is then owned by the UART); the next
//     byte is only prepared after tx_busy has returned low.

module frame_uart_sender #(
  parameter int ADDR_W       = 14,
  parameter int LEN_W        = 14,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_valid,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [LEN_W-1:0]  frame_len,
  output logic              frame_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              overrun,
  output logic              tx_timeout,
  output logic [15:0]       frames_sent,
  output logic [2:0]        dbg_state
);

  // Timeout counter must be able to hold BUSY_TIMEOUT itself.
  localparam int TO_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT_RD = 3'd2,
    LAUNCH  = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  idx_next;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] rd_addr_d;

  logic              accept;
  logic              byte_done;
  logic              timeout_hit;
  logic              done_c;
  logic              aborted_c;

  // Only the low byte of each SPRAM word carries frame data.
  logic              unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[15:8];

  // Ready is held low during reset so every output reads 0 while rst is high.
  assign frame_ready = (state_q == IDLE) & enable & ~rst;
  assign accept      = frame_valid & frame_ready;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;
  assign done        = done_c;
  assign aborted     = aborted_c;

  assign idx_next  = idx_q + LEN_W'(1);
  assign byte_done = (state_q == DRAIN) & ~tx_busy;

  // First read of a frame uses the incoming base directly; later reads use
  // the captured base plus the next index. The sum wraps at 2^ADDR_W.
  assign rd_addr_d = (state_q == IDLE) ? frame_base
                                       : base_q + ADDR_W'(idx_next);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode plus the done/aborted/timeout decision pulses
  always_comb begin
    state_d     = state_q;
    done_c      = 1'b0;
    aborted_c   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (frame_len == '0) done_c  = 1'b1;
          else                 state_d = READ;
        end
      end
      READ:    state_d = WAIT_RD;
      WAIT_RD: state_d = LAUNCH;
      LAUNCH: begin
        // A busy-high sample wins over a timeout in the same cycle.
        if (tx_busy) begin
          state_d = DRAIN;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          aborted_c   = 1'b1;
          state_d     = IDLE;
        end
      end
      DRAIN: begin
        // The byte in flight always finishes; enable is only honoured here.
        if (!tx_busy) begin
          if (idx_next == len_q) begin
            done_c  = 1'b1;
            state_d = IDLE;
          end else if (!enable) begin
            aborted_c = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame context: capture base/length on accept, advance index per byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      base_q <= frame_base;
      len_q  <= frame_len;
      idx_q  <= '0;
    end else if (byte_done) begin
      idx_q <= idx_next;
    end
  end

  // SPRAM read port: one-cycle strobe on READ, address held while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      mem_rd_en <= (state_d == READ);
      if (state_d == READ) mem_addr <= rd_addr_d;
    end
  end

  // UART byte interface: latch read data, hold start for the whole LAUNCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= (state_d == LAUNCH);
      if (state_q == WAIT_RD) tx_data <= mem_rdata[7:0];
    end
  end

  // Counts LAUNCH cycles spent waiting for tx_busy to rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                to_cnt <= '0;
    else if (state_q == LAUNCH && !tx_busy) to_cnt <= to_cnt + TO_W'(1);
    else                                    to_cnt <= '0;
  end

  // Sticky status flags and completed-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun     <= 1'b0;
      tx_timeout  <= 1'b0;
      frames_sent <= '0;
    end else begin
      if (frame_valid && !frame_ready) overrun    <= 1'b1;
      if (timeout_hit)                 tx_timeout <= 1'b1;
      if (done_c)                      frames_sent <= frames_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_uart_sender.sv
// Testbench for frame_uart_sender: SPRAM and uart_tx behavioural models,
// directed frame scenarios, and a per-cycle compare process against an
// expected address queue and expected byte queue.

module tb_frame_uart_sender;

  localparam int ADDR_W       = 14;
  localparam int LEN_W        = 14;
  localparam int BUSY_TIMEOUT = 8;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              frame_valid;
  logic [ADDR_W-1:0] frame_base;
  logic [LEN_W-1:0]  frame_len;
  logic              frame_ready;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              overrun;
  logic              tx_timeout;
  logic [15:0]       frames_sent;
  logic [2:0]        dbg_state_unused;

  frame_uart_sender #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .frame_valid(frame_valid), .frame_base(frame_base), .frame_len(frame_len),
    .frame_ready(frame_ready), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .busy(busy), .done(done), .aborted(aborted),
    .overrun(overrun), .tx_timeout(tx_timeout), .frames_sent(frames_sent),
    .dbg_state(dbg_state_unused)
  );

  // ---------------- clock / reset / cycle count ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [13:0] addr_q[$];
  logic [7:0]  got_q[$];
  logic [13:0] got_addr[$];
  logic [7:0]  mem [0:16383];

  int frame_seq = 0;
  int acc_cyc = 0;
  int done_base = 0;
  int abort_base = 0;

  // owned by the compare process
  int done_cnt = 0;
  int abort_cnt = 0;
  int first_rd_cyc = -1;
  int first_start_cyc = -1;
  int done_cyc = -1;
  int abort_cyc = -1;
  int start_cycles = 0;
  int start_rises = 0;

  // uart model knobs
  int   busy_delay = 2;
  int   busy_hold = 20;
  logic uart_dead = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: frame bytes are mem[(base+i) mod 2^14] in index order
  task automatic expect_bytes(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [13:0] a;
      a = 14'((b + i) % 16384);
      addr_q.push_back(a);
      exp_q.push_back(mem[a]);
    end
  endtask

  task automatic send(input logic [13:0] b, input logic [13:0] l);
    frame_seq++;
    done_base   = done_cnt;
    abort_base  = abort_cnt;
    frame_base  = b;
    frame_len   = l;
    frame_valid = 1'b1;
    acc_cyc     = cyc;
    step();
    frame_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (done_cnt == done_base && abort_cnt == abort_base && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("frame_end_wait", 32'(n), 32'(budget - 1));
  endtask

  // ---------------- SPRAM model: data one cycle after rd_en ----------------
  initial begin
    logic        rd_pend;
    logic [13:0] rd_a;
    rd_pend   = 1'b0;
    rd_a      = '0;
    mem_rdata = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      if (rd_pend) mem_rdata = {8'h5A, mem[rd_a]};
      else         mem_rdata = 16'hDEAD;
      rd_pend = mem_rd_en;
      rd_a    = mem_addr;
    end
  end

  // ---------------- uart_tx model ----------------
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start && !uart_dead && !tx_busy) begin
        repeat (busy_delay) begin
          @(posedge clk);
          #1;
        end
        tx_busy = 1'b1;
        repeat (busy_hold) begin
          @(posedge clk);
          #1;
        end
        tx_busy = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    int         seen_seq;
    logic       prev_start;
    logic       prev_busy;
    logic       have_fall;
    int         fall_cyc;
    logic [7:0] launch_data;
    seen_seq = 0; prev_start = 0; prev_busy = 0; have_fall = 0;
    fall_cyc = 0; launch_data = '0;
    forever begin
      @(negedge clk);
      if (frame_seq != seen_seq) begin
        seen_seq = frame_seq;
        first_rd_cyc = -1; first_start_cyc = -1; done_cyc = -1; abort_cyc = -1;
        start_cycles = 0; start_rises = 0; have_fall = 0;
        got_q.delete();
        got_addr.delete();
      end
      check("ready_rule", {31'd0, frame_ready}, {31'd0, !busy && enable && !rst});
      if (tx_start && !busy)  check("start_while_idle", 32'd1, 32'd0);
      if (mem_rd_en && !busy) check("read_while_idle", 32'd1, 32'd0);
      if (done && aborted)    check("done_and_aborted", 32'd1, 32'd0);
      if (mem_rd_en) begin
        got_addr.push_back(mem_addr);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (addr_q.size() == 0) check("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
        else                    check("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (tx_start && !prev_start) begin
        start_rises++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
        launch_data = tx_data;
        if (have_fall) begin
          check("byte_gap", 32'(cyc - fall_cyc), 32'd3);
          have_fall = 0;
        end
      end
      if (tx_start) begin
        start_cycles++;
        if (prev_start) check("tx_data_stable", 32'(tx_data), 32'(launch_data));
      end
      if (tx_start && tx_busy) begin
        got_q.push_back(tx_data);
        if (exp_q.size() == 0) check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else                   check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (prev_busy && !tx_busy && busy) begin
        fall_cyc  = cyc;
        have_fall = 1;
      end
      if (done)    begin done_cnt++;  done_cyc  = cyc; end
      if (aborted) begin abort_cnt++; abort_cyc = cyc; end
      prev_start = tx_start;
      prev_busy  = tx_busy;
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [7:0]  lit_b[3];
    logic [13:0] lit_a[4];
    int          n;
    lit_b = '{8'hA1, 8'hB2, 8'hC3};
    lit_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};

    rst = 1'b1; enable = 1'b0; frame_valid = 1'b0;
    frame_base = '0; frame_len = '0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 37 + 11);
    mem[14'h0010] = 8'hA1; mem[14'h0011] = 8'hB2; mem[14'h0012] = 8'hC3;
    mem[14'h3FFE] = 8'h11; mem[14'h3FFF] = 8'h22;
    mem[14'h0000] = 8'h33; mem[14'h0001] = 8'h44;

    step(3);
    rst = 1'b0;
    step();
    // reset state
    check("rst_frames_sent", 32'(frames_sent), 32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_rd_en",       32'(mem_rd_en),   32'd0);
    check("rst_tx_start",    32'(tx_start),    32'd0);
    check("rst_overrun",     32'(overrun),     32'd0);
    check("rst_tx_timeout",  32'(tx_timeout),  32'd0);
    check("rst_ready_dis",   32'(frame_ready), 32'd0);
    enable = 1'b1;
    #1;
    check("ready_enabled",   32'(frame_ready), 32'd1);

    // 1: three-byte frame, latency and byte order
    step();
    expect_bytes(16'h0010, 3);
    send(14'h0010, 14'd3);
    wait_end(300);
    check("t1_rd_latency",    32'(first_rd_cyc - acc_cyc),    32'd1);
    check("t1_start_latency", 32'(first_start_cyc - acc_cyc), 32'd3);
    check("t1_done",          32'(done_cnt - done_base),      32'd1);
    check("t1_aborted",       32'(abort_cnt - abort_base),    32'd0);
    check("t1_frames_sent",   32'(frames_sent),               32'd1);
    check("t1_nbytes",        32'(got_q.size()),              32'd3);
    if (got_q.size() == 3)
      for (int i = 0; i < 3; i++) check("t1_byte_lit", 32'(got_q[i]), 32'(lit_b[i]));

    // 2: zero-length frame completes in the accept cycle
    step(2);
    send(14'h0040, 14'd0);
    step(2);
    check("t2_done_cycle",  32'(done_cyc - acc_cyc),   32'd0);
    check("t2_done",        32'(done_cnt - done_base), 32'd1);
    check("t2_no_read",     32'(first_rd_cyc),         32'hFFFF_FFFF);
    check("t2_no_start",    32'(start_rises),          32'd0);
    check("t2_frames_sent", 32'(frames_sent),          32'd2);
    check("t2_busy",        32'(busy),                 32'd0);

    // 3: address wraps past the top of SPRAM
    expect_bytes(16'h3FFE, 4);
    send(14'h3FFE, 14'd4);
    wait_end(400);
    check("t3_done",        32'(done_cnt - done_base), 32'd1);
    check("t3_frames_sent", 32'(frames_sent),          32'd3);
    check("t3_nbytes",      32'(got_q.size()),         32'd4);
    check("t3_nreads",      32'(got_addr.size()),      32'd4);
    if (got_addr.size() == 4)
      for (int i = 0; i < 4; i++) check("t3_addr_lit", 32'(got_addr[i]), 32'(lit_a[i]));

    // 4: enable drops during second byte's LAUNCH
    step(2);
    expect_bytes(16'h0080, 2);
    send(14'h0080, 14'd5);
    n = 0;
    while (start_rises < 2 && n < 200) begin step(); n++; end
    if (n >= 200) check("t4_second_start_wait", 32'(n), 32'd199);
    enable = 1'b0;
    wait_end(300);
    check("t4_aborted",     32'(abort_cnt - abort_base), 32'd1);
    check("t4_done",        32'(done_cnt - done_base),   32'd0);
    check("t4_nbytes",      32'(got_q.size()),           32'd2);
    check("t4_frames_sent", 32'(frames_sent),            32'd3);
    step();
    check("t4_ready_low",   32'(frame_ready),            32'd0);
    check("t4_busy",        32'(busy),                   32'd0);
    enable = 1'b1;
    #1;
    check("t4_ready_back",  32'(frame_ready),            32'd1);

    // 5a: frame_valid while busy -> overrun, frame dropped
    step();
    expect_bytes(16'h0100, 2);
    send(14'h0100, 14'd2);
    step(5);
    frame_base = 14'h0200; frame_len = 14'd1; frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    check("t5_overrun_set",  32'(overrun), 32'd1);
    wait_end(300);
    check("t5_done",         32'(done_cnt - done_base), 32'd1);
    check("t5_nbytes",       32'(got_q.size()),         32'd2);
    check("t5_frames_sent",  32'(frames_sent),          32'd4);

    // 5b: tx_busy never rises -> timeout after 8 LAUNCH cycles
    uart_dead = 1'b1;
    step();
    addr_q.push_back(14'h0300);
    send(14'h0300, 14'd3);
    wait_end(100);
    check("t5_to_aborted",     32'(abort_cnt - abort_base), 32'd1);
    check("t5_to_done",        32'(done_cnt - done_base),   32'd0);
    check("t5_launch_cycles",  32'(start_cycles),           32'd8);
    check("t5_abort_cycle",    32'(abort_cyc - acc_cyc),    32'd10);
    check("t5_tx_timeout",     32'(tx_timeout),             32'd1);
    check("t5_overrun_sticky", 32'(overrun),                32'd1);
    check("t5_idle",           32'(busy),                   32'd0);
    check("t5_start_low",      32'(tx_start),               32'd0);
    check("t5_frames_same",    32'(frames_sent),            32'd4);
    uart_dead = 1'b0;

    // 6: asynchronous reset in DRAIN, then a normal frame
    step(2);
    expect_bytes(16'h0010, 3);
    send(14'h0010, 14'd3);
    n = 0;
    while (!(busy && tx_busy && !tx_start) && n < 100) begin step(); n++; end
    if (n >= 100) check("t6_drain_wait", 32'(n), 32'd99);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_busy",       32'(busy),        32'd0);
    check("t6_rst_tx_start",   32'(tx_start),    32'd0);
    check("t6_rst_rd_en",      32'(mem_rd_en),   32'd0);
    check("t6_rst_frames",     32'(frames_sent), 32'd0);
    check("t6_rst_overrun",    32'(overrun),     32'd0);
    check("t6_rst_tx_timeout", 32'(tx_timeout),  32'd0);
    check("t6_rst_ready",      32'(frame_ready), 32'd0);
    check("t6_rst_done",       32'(done),        32'd0);
    check("t6_rst_aborted",    32'(aborted),     32'd0);
    check("t6_rst_tx_data",    32'(tx_data),     32'd0);
    addr_q.delete();
    exp_q.delete();
    step(2);
    rst = 1'b0;
    n = 0;
    while (tx_busy && n < 100) begin step(); n++; end
    step();
    expect_bytes(16'h0012, 1);
    send(14'h0012, 14'd1);
    wait_end(200);
    check("t6_done",           32'(done_cnt - done_base),      32'd1);
    check("t6_start_latency",  32'(first_start_cyc - acc_cyc), 32'd3);
    check("t6_frames_sent",    32'(frames_sent),               32'd1);
    check("t6_nbytes",         32'(got_q.size()),              32'd1);
    if (got_q.size() == 1) check("t6_byte_lit", 32'(got_q[0]), 32'h0000_00C3);

    step(3);
    check("left_exp_bytes", 32'(exp_q.size()),  32'd0);
    check("left_exp_addrs", 32'(addr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
